// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM state encoding and constants for the RO-PUF response generator
package ro_puf_pkg;
  localparam int CLEAR_CYCLES = 2;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    SETTLE,
    COMPARE,
    DONE
  } state_t;
endpackage

// File: rtl/ro_puf_phase_timer.sv
// ro_puf_phase_timer: loadable down-counter whose done pulse marks the last cycle of a phase
module ro_puf_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] r_cnt;
  logic         r_run;
  assign done = r_run && (r_cnt == '0);
  // load starts a phase of load_val+1 cycles; done fires once on its final cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_cnt <= load_val;
      r_run <= 1'b1;
    end else if (done) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt - W'(1);
    end
  end
endmodule

// File: rtl/ro_puf_response_gen.sv
// ro_puf_response_gen: sequences RO-pair measurements into a response word; RO_PUF_TIE_FLAG_EN adds tie_mask
module ro_puf_response_gen
  import ro_puf_pkg::*;
#(
  parameter int CHAL_W        = 8,
  parameter int RESP_BITS     = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge,
  output logic [CHAL_W-1:0]    ro_sel,
  output logic                 cnt_rst,
  output logic                 cnt_en,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic [RESP_BITS-1:0] response,
`ifdef RO_PUF_TIE_FLAG_EN
  output logic [RESP_BITS-1:0] tie_mask,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);
  localparam int IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TW = $clog2(CLEAR_CYCLES + WINDOW_CYCLES + SETTLE_CYCLES);

  state_t          r_state, w_nxt;
  logic [IW-1:0]   r_bit_idx, w_idx_nxt;
  logic [CHAL_W-1:0] r_chal;
  logic            w_last, w_done, w_load, w_accept;
  logic [TW-1:0]   w_load_val;

  assign w_last    = (r_bit_idx == IW'(RESP_BITS - 1));
  assign w_idx_nxt = r_bit_idx + IW'(1);
  assign w_accept  = (r_state == IDLE) && start;

  ro_puf_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_done)
  );

  // next-state logic; each timed phase loads the timer with its length minus one on entry
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: if (start) begin
        w_nxt      = CLEAR;
        w_load     = 1'b1;
        w_load_val = TW'(CLEAR_CYCLES - 1);
      end
      CLEAR: if (w_done) begin
        w_nxt      = COUNT;
        w_load     = 1'b1;
        w_load_val = TW'(WINDOW_CYCLES - 1);
      end
      COUNT: if (w_done) begin
        w_nxt      = SETTLE;
        w_load     = 1'b1;
        w_load_val = TW'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (w_done) w_nxt = COMPARE;
      COMPARE: if (w_last) begin
        w_nxt = DONE;
      end else begin
        w_nxt      = CLEAR;
        w_load     = 1'b1;
        w_load_val = TW'(CLEAR_CYCLES - 1);
      end
      DONE: if (resp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // state register with control outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      cnt_rst    <= 1'b1;
      cnt_en     <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      cnt_rst    <= (w_nxt == CLEAR);
      cnt_en     <= (w_nxt == COUNT);
      resp_valid <= (w_nxt == DONE);
      busy       <= (w_nxt != IDLE);
    end
  end

  // challenge latch, bit index, oscillator select and response accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chal    <= '0;
      r_bit_idx <= '0;
      ro_sel    <= '0;
      response  <= '0;
    end else if (w_accept) begin
      r_chal    <= challenge;
      r_bit_idx <= '0;
      ro_sel    <= challenge;
      response  <= '0;
    end else if (r_state == COMPARE) begin
      response[r_bit_idx] <= (count_a > count_b);
      if (!w_last) begin
        r_bit_idx <= w_idx_nxt;
        ro_sel    <= r_chal + CHAL_W'(w_idx_nxt);
      end
    end
  end

`ifdef RO_PUF_TIE_FLAG_EN
  // tie flags recorded alongside each response bit
  always_ff @(posedge clk) begin
    if (rst || w_accept) tie_mask <= '0;
    else if (r_state == COMPARE) tie_mask[r_bit_idx] <= (count_a == count_b);
  end
`endif
endmodule
